// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory responder: load/store flags, FSM states,
// and helpers that turn a flag into an access size and a byte-lane mask.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    LF_LB  = 3'b000,
    LF_LH  = 3'b001,
    LF_LW  = 3'b010,
    LF_LD  = 3'b011,
    LF_LBU = 3'b100,
    LF_LHU = 3'b101,
    LF_LWU = 3'b110,
    LF_ILL = 3'b111
  } load_flag_e;

  typedef enum logic [1:0] {
    SF_SB = 2'b00,
    SF_SH = 2'b01,
    SF_SW = 2'b10,
    SF_SD = 2'b11
  } store_flag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // The low two flag bits encode log2(size) for both loads and stores; the
  // illegal load code lands on 8 bytes but is rejected separately.
  function automatic logic [3:0] access_size(input logic       is_write,
                                             input logic [2:0] load_flag,
                                             input logic [1:0] store_flag);
    logic [1:0] w_log2;
    w_log2 = is_write ? store_flag : load_flag[1:0];
    return 4'd1 << w_log2;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [3:0] size);
    logic [8:0] w_m;
    w_m = (9'd1 << size) - 9'd1;
    return w_m[7:0];
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed RAM with 8 consecutive byte lanes starting at any address.
// Combinational 8-byte read, per-lane synchronous write; lanes past the end are ignored/read 0.
module mem_byte_array #(
  parameter int MEM_DEPTH = 2048,
  parameter int AW        = 11
) (
  input  logic          clk,
  input  logic [7:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wdata,
  output logic [63:0]   o_rdata
);

  localparam int AW1 = AW + 1;

  logic [7:0]    r_mem [MEM_DEPTH];
  logic [AW-1:0] w_idx [8];
  logic [7:0]    w_ok;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [AW:0] w_pos;
    assign w_pos             = {1'b0, i_addr} + AW1'(k);
    assign w_ok[k]           = w_pos < AW1'(MEM_DEPTH);
    assign w_idx[k]          = w_pos[AW-1:0];
    assign o_rdata[8*k +: 8] = w_ok[k] ? r_mem[w_idx[k]] : 8'h00;
  end

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (i_we[k] && w_ok[k]) begin
        r_mem[w_idx[k]] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder over a byte RAM: response valid exactly LATENCY edges after accept,
// held until rsp_ready; req_ready only while idle, so a held response backpressures requests.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 2048,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_load_flag,
  input  logic [1:0]  req_store_flag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [2:0]  r_load_flag;
  logic [1:0]  r_store_flag;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_access;
  logic [3:0]  w_size;
  logic [64:0] w_last;
  logic        w_err;
  logic [7:0]  w_we;
  logic [63:0] w_mem_rdata;
  logic [63:0] w_load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Last touched byte is formed at 65 bits so huge addresses cannot wrap into range.
  assign w_size = access_size(r_write, r_load_flag, r_store_flag);
  assign w_last = {1'b0, r_addr} + 65'(w_size) - 65'd1;
  assign w_err  = (w_last >= 65'(MEM_DEPTH)) || (!r_write && (r_load_flag == LF_ILL));
  assign w_we   = (w_access && r_write && !w_err && !rst) ? lane_mask(w_size) : 8'h00;

  mem_byte_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_comb begin
    w_load_data = 64'h0;
    case (r_load_flag)
      LF_LB:   w_load_data = {{56{w_mem_rdata[7]}},  w_mem_rdata[7:0]};
      LF_LH:   w_load_data = {{48{w_mem_rdata[15]}}, w_mem_rdata[15:0]};
      LF_LW:   w_load_data = {{32{w_mem_rdata[31]}}, w_mem_rdata[31:0]};
      LF_LD:   w_load_data = w_mem_rdata;
      LF_LBU:  w_load_data = {56'h0, w_mem_rdata[7:0]};
      LF_LHU:  w_load_data = {48'h0, w_mem_rdata[15:0]};
      LF_LWU:  w_load_data = {32'h0, w_mem_rdata[31:0]};
      default: w_load_data = 64'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_rdata <= 64'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= 4'(LATENCY - 1);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? 64'h0 : w_load_data;
      end
    end
  end

  // Request fields are only consumed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_write      <= req_write;
      r_addr       <= req_addr;
      r_wdata      <= req_wdata;
      r_load_flag  <= req_load_flag;
      r_store_flag <= req_store_flag;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 2048, meaning data memory size in bytes.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15, meaning clock edges from request accept to response valid.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1, meaning 1=store, 0=load.
REQ-008 SHALL have port req_addr, input, 64, meaning byte address.
REQ-009 SHALL have port req_wdata, input, 64, meaning store data, LSB-aligned.
REQ-010 SHALL have port req_load_flag, input, 3, meaning load type: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu, 111 illegal.
REQ-011 SHALL have port req_store_flag, input, 2, meaning store type: 00 sb, 01 sh, 10 sw, 11 sd.
REQ-012 SHALL have port rsp_valid, output, 1, meaning the response is presented.
REQ-013 SHALL have port rsp_ready, input, 1, meaning the initiator takes the response.
REQ-014 SHALL have port rsp_rdata, output, 64, meaning load result, extended per load type; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1, meaning out-of-range address or illegal load type.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept occurs on an edge where req_valid & req_ready.
REQ-018 SHALL, on accept, register write, addr, wdata and flags, load the wait counter with LATENCY-1 and enter WAIT; request inputs are ignored afterwards.
REQ-019 SHALL decrement the counter each WAIT cycle; on the edge where it is 0, perform the access, register rsp_rdata/rsp_err and enter RESP.
REQ-020 SHALL therefore raise rsp_valid exactly LATENCY edges after the accept edge.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge with rsp_valid=0; req_ready is high in the next cycle (one bubble).
REQ-022 SHALL use little-endian byte order; access size is 1/2/4/8 bytes per flag; no alignment restriction.
REQ-023 SHALL sign-extend lb/lh/lw and zero-extend lbu/lhu/lwu to 64 bits; ld returns 8 bytes unmodified.
REQ-024 SHALL, for stores, write only the low 1/2/4/8 bytes of wdata at addr..addr+size-1.
REQ-025 SHALL flag rsp_err=1 when addr+size-1 >= MEM_DEPTH (compared at full 64-bit width, no wrap), or load flag is 111; no memory change and rsp_rdata=0 in that case.
REQ-026 SHALL make a store visible to any load accepted after the store's response handshake.

Reset
REQ-027 SHALL, with rst=1 at an edge, force IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready is 1 in the cycle after reset deasserts.
REQ-028 SHALL, on reset in WAIT before the access edge, discard the transaction and leave memory unchanged; in RESP, drop the response.
REQ-029 SHALL NOT clear memory contents on reset; rst has priority over all other events.

Structure
REQ-030 SHALL place load/store flag encodings, the FSM state type and an access-size function in shared package riscv_mem_pkg.
REQ-031 SHALL instantiate one sub-module, mem_byte_array: MEM_DEPTH x 8 byte RAM with 8 byte-lane write enables and 8-byte read.

Verification
REQ-032 SHALL cover: sd 0x1122334455667788 to addr 16, then ld addr 16 -> rdata 0x1122334455667788, err 0, rsp_valid exactly LATENCY edges after each accept.
REQ-033 SHALL cover: sb 0x80 to addr 5; lb addr 5 -> 0xFFFFFFFFFFFFFF80; lbu addr 5 -> 0x0000000000000080.
REQ-034 SHALL cover: sw 0xDEADBEEF to misaligned addr 3; lh addr 3 -> 0xFFFFFFFFFFFFBEEF; lwu addr 3 -> 0x00000000DEADBEEF.
REQ-035 SHALL cover: ld addr 2041 (MEM_DEPTH 2048) -> err 1, rdata 0; sd addr 2044 -> err 1, bytes 2044..2047 unchanged; load flag 111 -> err 1.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0 throughout, new req_valid ignored.
REQ-037 SHALL cover: rst during WAIT of sd 0xFF.. to addr 0 -> subsequent ld addr 0 returns the prior contents, outputs at reset values.
